// File: rtl/block_mem_pkg.sv
// Shared types and address helpers for the 2x2-interleaved block frame memory port logic.
// Block address layout is {x[6:0], y[5:0]}; a quad spans (x..x+1, y..y+1).
package block_mem_pkg;

  localparam int BLK_ADDR_W     = 13;
  localparam int X_W            = 7;
  localparam int Y_W            = 6;
  localparam int BLOCKS_PER_ROW = 36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_e;

  // True when the whole quad rooted at addr lies inside a frame whose largest block is (max_x, max_y).
  function automatic logic quad_in_range(input logic [BLK_ADDR_W-1:0] addr,
                                         input int max_x,
                                         input int max_y);
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    x = addr[BLK_ADDR_W-1 -: X_W];
    y = addr[Y_W-1:0];
    return (int'(x) < max_x) && (int'(y) < max_y);
  endfunction

endpackage

// File: rtl/block_mem_rd_pipe.sv
// Read-return tracker: RD_LAT-deep {valid, tag} shift register, cleared by flush.
// Output appears exactly RD_LAT cycles after entry; accepts one entry per cycle, no backpressure.
module block_mem_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             inflight
);

  logic [RD_LAT-1:0] vld;
  logic [TAG_W-1:0]  tag [RD_LAT];

  always_ff @(posedge clk) begin
    if (flush) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      tag[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_tag   = tag[RD_LAT-1];
  assign inflight  = |vld;

endmodule

// File: rtl/block_mem_port_arbiter.sv
// Port-A sequencer for the block frame memory: same-cycle reader/writer grant with burst-limited round-robin,
// quad range check and RD_LAT-aligned tagged read strobe. BLOCK_MEM_ARB_STATS_EN adds grant/error/contention counters.
module block_mem_port_arbiter
  import block_mem_pkg::*;
#(
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 4,
  parameter int MAX_X     = 71,
  parameter int MAX_Y     = 55,
  parameter int TAG_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [BLK_ADDR_W-1:0] wr_addr,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [BLK_ADDR_W-1:0] rd_addr,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_valid_tag,
  output logic                  addr_err,
  output logic [BLK_ADDR_W-1:0] block_address_a,
  output logic                  wren,
  output logic                  clk_en_a,
  output logic                  busy
`ifdef BLOCK_MEM_ARB_STATS_EN
  ,
  output logic [31:0]           rd_grants,
  output logic [31:0]           wr_grants,
  output logic [31:0]           err_count,
  output logic [31:0]           contention_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e            state;
  arb_state_e            grant;
  arb_state_e            last_grant;
  logic [CNT_W-1:0]      burst_cnt;
  logic [BLK_ADDR_W-1:0] addr_hold;
  logic [BLK_ADDR_W-1:0] grant_addr;
  logic                  issue;
  logic                  grant_ok;
  logic                  pipe_valid;
  logic [TAG_W-1:0]      pipe_tag;
  logic                  inflight;

  // The grant is decided and presented in the same cycle as the request, so a held request is issued exactly once.
  always_comb begin
    grant = IDLE;
    if (!rst) begin
      if (rd_req && wr_req) begin
        if (state == IDLE)
          grant = (last_grant == WR) ? RD : WR;
        else if (burst_cnt < CNT_W'(MAX_BURST))
          grant = state;
        else
          grant = (state == RD) ? WR : RD;
      end else if (rd_req) begin
        grant = RD;
      end else if (wr_req) begin
        grant = WR;
      end
    end
  end

  assign grant_addr = (grant == RD) ? rd_addr : wr_addr;
  assign issue      = (grant != IDLE);
  assign grant_ok   = quad_in_range(grant_addr, MAX_X, MAX_Y);

  assign rd_ack   = (grant == RD) && grant_ok;
  assign wr_ack   = (grant == WR) && grant_ok;
  assign addr_err = issue && !grant_ok;
  assign wren     = wr_ack;

  assign block_address_a = rst ? '0 : (issue ? grant_addr : addr_hold);
  assign clk_en_a        = !rst && (issue || inflight);
  assign busy            = !rst && ((state != IDLE) || inflight);
  assign rd_valid        = !rst && pipe_valid;
  assign rd_valid_tag    = rst ? '0 : pipe_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= WR;
      burst_cnt  <= '0;
      addr_hold  <= '0;
    end else begin
      state <= grant;
      if (issue) begin
        addr_hold  <= grant_addr;
        last_grant <= grant;
      end
      if (!issue)
        burst_cnt <= '0;
      else if (grant != state)
        burst_cnt <= CNT_W'(1);
      else if (burst_cnt < CNT_W'(MAX_BURST))
        burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  block_mem_rd_pipe #(
    .RD_LAT (RD_LAT),
    .TAG_W  (TAG_W)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (rd_ack),
    .in_tag    (rd_tag),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag),
    .inflight  (inflight)
  );

`ifdef BLOCK_MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_grants         <= '0;
      wr_grants         <= '0;
      err_count         <= '0;
      contention_cycles <= '0;
    end else begin
      if (rd_ack && (rd_grants != '1))   rd_grants <= rd_grants + 32'd1;
      if (wr_ack && (wr_grants != '1))   wr_grants <= wr_grants + 32'd1;
      if (addr_err && (err_count != '1)) err_count <= err_count + 32'd1;
      if (rd_req && wr_req && (contention_cycles != '1))
        contention_cycles <= contention_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_mem_port_arbiter.sv
// Bench for block_mem_port_arbiter: directed scenarios plus randomized requesters, all checked against a cycle reference model.
module tb_block_mem_port_arbiter;

  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;
  localparam int TAG_W     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [12:0] wr_addr = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [12:0] rd_addr = '0;
  logic [3:0]  rd_tag = '0;
  logic        rd_ack;
  logic        rd_valid;
  logic [3:0]  rd_valid_tag;
  logic        addr_err;
  logic [12:0] block_address_a;
  logic        wren;
  logic        clk_en_a;
  logic        busy;
`ifdef BLOCK_MEM_ARB_STATS_EN
  logic [31:0] rd_grants, wr_grants, err_count, contention_cycles;
`endif

  block_mem_port_arbiter #(
    .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST), .MAX_X(71), .MAX_Y(55), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_valid_tag(rd_valid_tag), .addr_err(addr_err),
    .block_address_a(block_address_a), .wren(wren), .clk_en_a(clk_en_a), .busy(busy)
`ifdef BLOCK_MEM_ARB_STATS_EN
    , .rd_grants(rd_grants), .wr_grants(wr_grants), .err_count(err_count),
    .contention_cycles(contention_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: grant rules as plain integers ----------------
  int          cyc = 0;
  int          m_owner = 0;   // 0 none, 1 reader, 2 writer (who was granted last cycle)
  int          m_run = 0;     // grants in the current run of one owner
  int          m_last = 2;    // last requester ever granted
  logic [12:0] m_hold = '0;
  int          due_q[$];
  logic [3:0]  tag_q[$];
  bit          rd_done = 0, wr_done = 0;
  int          m_rdg = 0, m_wrg = 0, m_err = 0, m_cont = 0;

  always @(negedge clk) begin
    int          g;
    logic [12:0] a;
    int          x, y, n_fly;
    bit          legal, exp_rv;
    cyc++;
    if (rst) begin
      m_owner = 0; m_run = 0; m_last = 2; m_hold = '0;
      due_q.delete(); tag_q.delete();
      rd_done = 0; wr_done = 0;
      m_rdg = 0; m_wrg = 0; m_err = 0; m_cont = 0;
    end else begin
      if (!rd_req && !wr_req)  g = 0;
      else if (!wr_req)        g = 1;
      else if (!rd_req)        g = 2;
      else if (m_owner == 0)   g = (m_last == 2) ? 1 : 2;
      else if (m_run < MAX_BURST) g = m_owner;
      else                     g = 3 - m_owner;
      a = (g == 1) ? rd_addr : wr_addr;
      x = a / 64;
      y = a % 64;
      legal = (x + 1 <= 71) && (y + 1 <= 55);
      n_fly = due_q.size();
      exp_rv = (n_fly > 0) && (due_q[0] == cyc);

      check_eq("rd_ack",   32'(rd_ack),   32'(g == 1 && legal));
      check_eq("wr_ack",   32'(wr_ack),   32'(g == 2 && legal));
      check_eq("addr_err", 32'(addr_err), 32'(g != 0 && !legal));
      check_eq("wren",     32'(wren),     32'(g == 2 && legal));
      check_eq("baddr",    32'(block_address_a), 32'((g != 0) ? a : m_hold));
      check_eq("clk_en",   32'(clk_en_a), 32'(g != 0 || n_fly > 0));
      check_eq("busy",     32'(busy),     32'(m_owner != 0 || n_fly > 0));
      check_eq("rd_valid", 32'(rd_valid), 32'(exp_rv));
      if (exp_rv) begin
        check_eq("rd_tag", 32'(rd_valid_tag), 32'(tag_q[0]));
        void'(due_q.pop_front());
        void'(tag_q.pop_front());
      end

      if (g == 1 && legal) begin
        due_q.push_back(cyc + RD_LAT);
        tag_q.push_back(rd_tag);
        m_rdg++;
      end
      if (g == 2 && legal) m_wrg++;
      if (g != 0 && !legal) m_err++;
      if (rd_req && wr_req) m_cont++;
      if (g != 0) m_hold = a;
      if (g == 0)            m_run = 0;
      else if (g != m_owner) m_run = 1;
      else if (m_run < MAX_BURST) m_run++;
      if (g != 0) m_last = g;
      m_owner = g;
      rd_done = (g == 1);
      wr_done = (g == 2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] xy(input int x, input int y);
    return {7'(x), 6'(y)};
  endfunction

  function automatic logic [12:0] rand_addr();
    int r = $urandom_range(0, 9);
    int x = $urandom_range(0, 70);
    int y = $urandom_range(0, 54);
    if (r == 0)      x = $urandom_range(71, 127);
    else if (r == 1) y = $urandom_range(55, 63);
    else if (r == 2) begin x = 70; y = 54; end
    return xy(x, y);
  endfunction

  initial begin
    // reset state
    repeat (2) step();
    @(negedge clk);
    check_eq("rst_rd_ack",   32'(rd_ack), 0);
    check_eq("rst_wr_ack",   32'(wr_ack), 0);
    check_eq("rst_rd_valid", 32'(rd_valid), 0);
    check_eq("rst_clk_en",   32'(clk_en_a), 0);
    check_eq("rst_baddr",    32'(block_address_a), 0);
    check_eq("rst_busy",     32'(busy), 0);

    // contention straight out of reset: reader gets the first burst
    step();
    rst = 0; rd_req = 1; wr_req = 1; rd_addr = xy(1, 1); wr_addr = xy(2, 2); rd_tag = 4'h3;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("cont_rd", 32'(rd_ack), 32'(i < 4 || i >= 8));
      check_eq("cont_wr", 32'(wr_ack), 32'(i >= 4 && i < 8));
      if (i < 11) step();
    end
    step();
    rd_req = 0; wr_req = 0;
    @(negedge clk);
`ifdef BLOCK_MEM_ARB_STATS_EN
    check_eq("stat_cont_rd",   rd_grants, 8);
    check_eq("stat_cont_wr",   wr_grants, 4);
    check_eq("stat_cont_wait", contention_cycles, 12);
`endif
    repeat (4) step();

    // reader only, three back-to-back reads
    rd_req = 1; rd_addr = xy(5, 3); rd_tag = 4'hA;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("ro_clk_en", 32'(clk_en_a), 32'(i <= 4));
      check_eq("ro_valid",  32'(rd_valid), 32'(i >= 2 && i <= 4));
      if (i >= 2 && i <= 4) check_eq("ro_tag", 32'(rd_valid_tag), 32'(10 + i - 2));
      step();
      if (i == 0) rd_tag = 4'hB;
      if (i == 1) rd_tag = 4'hC;
      if (i == 2) rd_req = 0;
    end

    // range boundaries
    wr_req = 1; wr_addr = xy(71, 0);
    @(negedge clk);
    check_eq("rng_wr_err", 32'(addr_err), 1);
    check_eq("rng_wren",   32'(wren), 0);
    step();
    wr_req = 0; rd_req = 1; rd_addr = xy(0, 55); rd_tag = 4'h5;
    @(negedge clk);
    check_eq("rng_rd_err", 32'(addr_err), 1);
    check_eq("rng_rd_ack", 32'(rd_ack), 0);
    step();
    rd_req = 0;
    repeat (3) step();
    rd_req = 1; rd_addr = xy(70, 54); rd_tag = 4'h6;
    @(negedge clk);
    check_eq("rng_rd_ok", 32'(rd_ack), 1);
    step();
    rd_req = 0; wr_req = 1; wr_addr = xy(70, 54);
    @(negedge clk);
    check_eq("rng_wr_ok", 32'(wren), 1);
    step();
    wr_req = 0;
    repeat (3) step();

    // write then read of the same quad
    wr_req = 1; wr_addr = xy(10, 10);
    @(negedge clk);
    check_eq("wtr_wren1", 32'(wren), 1);
    step();
    wr_req = 0; rd_req = 1; rd_addr = xy(10, 10); rd_tag = 4'h7;
    @(negedge clk);
    check_eq("wtr_wren0", 32'(wren), 0);
    check_eq("wtr_addr",  32'(block_address_a), 32'(xy(10, 10)));
    step();
    rd_req = 0;
    step();
    @(negedge clk);
    check_eq("wtr_valid", 32'(rd_valid), 1);
    repeat (3) step();

    // reset one cycle after a read issue
    rd_req = 1; rd_addr = xy(3, 4); rd_tag = 4'h9;
    step();
    rd_req = 0; rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mrst_valid", 32'(rd_valid), 0);
      if (i == 0) begin
        check_eq("mrst_baddr",  32'(block_address_a), 0);
        check_eq("mrst_clk_en", 32'(clk_en_a), 0);
        check_eq("mrst_busy",   32'(busy), 0);
      end
      step();
    end

    // randomized requesters holding each request until granted
    for (int i = 0; i < 600; i++) begin
      if (!rd_req || rd_done) begin
        rd_req = ($urandom_range(0, 3) != 0); rd_addr = rand_addr(); rd_tag = 4'($urandom);
      end
      if (!wr_req || wr_done) begin
        wr_req = ($urandom_range(0, 3) != 0); wr_addr = rand_addr();
      end
      rst = (i == 300);
      step();
    end
    rd_req = 0; wr_req = 0; rst = 0;
    repeat (4) step();
    @(negedge clk);
`ifdef BLOCK_MEM_ARB_STATS_EN
    check_eq("stat_rd",   rd_grants, 32'(m_rdg));
    check_eq("stat_wr",   wr_grants, 32'(m_wrg));
    check_eq("stat_err",  err_count, 32'(m_err));
    check_eq("stat_cont", contention_cycles, 32'(m_cont));
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
